l1_mem_arbiter: RTL and testbench

L1_MEM_ARBITER -- requirements
Module: l1_mem_arbiter

---
 rtl/l1_mem_arbiter_if.sv | 32 +++
 rtl/l1_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_l1_mem_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/l1_mem_arbiter_if.sv
// rtl/l1_mem_arbiter_if.sv - L1D/L1I miss ports and memory request/word-stream bundle for l1_mem_arbiter
interface l1_mem_arbiter_if #(
    parameter int DATA_W = 32
) ();
    logic              REQ_VALID_D, REQ_VALID_I;
    logic [DATA_W-1:0] ADDR_D, ADDR_I;
    logic              ACK_ADDR_D, ACK_ADDR_I;
    logic [3:0]        ACK_DATA_L1_D, ACK_DATA_L1_I;
    logic              READY_D, READY_I;
    logic [DATA_W-1:0] DATA_D, DATA_I;
    logic [3:0]        ACK_DATA_D, ACK_DATA_I;
    logic              RESET_ACK;
    logic              MEM_VALID, MEM_READY;
    logic [DATA_W-1:0] MEM_ADDR;
    logic              MEM_ACK_ADDR;
    logic [DATA_W-1:0] MEM_DATA;
    logic [3:0]        MEM_ACK_DATA, MEM_ACK_DATA_L1;

    modport slave (
        input  REQ_VALID_D, REQ_VALID_I, ADDR_D, ADDR_I, ACK_ADDR_D, ACK_ADDR_I,
               ACK_DATA_L1_D, ACK_DATA_L1_I, MEM_READY, MEM_DATA, MEM_ACK_DATA,
        output READY_D, READY_I, DATA_D, DATA_I, ACK_DATA_D, ACK_DATA_I, RESET_ACK,
               MEM_VALID, MEM_ADDR, MEM_ACK_ADDR, MEM_ACK_DATA_L1
    );

    modport master (
        output REQ_VALID_D, REQ_VALID_I, ADDR_D, ADDR_I, ACK_ADDR_D, ACK_ADDR_I,
               ACK_DATA_L1_D, ACK_DATA_L1_I, MEM_READY, MEM_DATA, MEM_ACK_DATA,
        input  READY_D, READY_I, DATA_D, DATA_I, ACK_DATA_D, ACK_DATA_I, RESET_ACK,
               MEM_VALID, MEM_ADDR, MEM_ACK_ADDR, MEM_ACK_DATA_L1
    );
endinterface

// File: rtl/l1_mem_arbiter.sv
// rtl/l1_mem_arbiter.sv - L1D/L1I line-fill arbiter onto one memory port; L1D_PRIORITY_EN selects fixed D priority
module l1_mem_arbiter #(
    parameter int WORDS_PER_LINE = 8,
    parameter int DATA_W         = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    l1_mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;

    localparam logic       OWN_D     = 1'b0;
    localparam logic       OWN_I     = 1'b1;
    localparam logic [3:0] LAST_WORD = 4'(WORDS_PER_LINE - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_ack_addr_q, mem_ack_addr_d;
    logic [3:0]        ack_l1_q, ack_l1_d;
    logic [3:0]        word_cnt_q, word_cnt_d;

    logic              req_owner, ack_addr_owner, winner;
    logic [3:0]        ack_l1_owner;
    logic [DATA_W-1:0] addr_owner;

`ifndef L1D_PRIORITY_EN
    logic last_grant_q, last_grant_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) last_grant_q <= OWN_I;
        else        last_grant_q <= last_grant_d;
    end
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q        <= IDLE;
            owner_q        <= OWN_D;
            mem_addr_q     <= '0;
            mem_ack_addr_q <= 1'b0;
            ack_l1_q       <= 4'hF;
            word_cnt_q     <= 4'd0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            mem_addr_q     <= mem_addr_d;
            mem_ack_addr_q <= mem_ack_addr_d;
            ack_l1_q       <= ack_l1_d;
            word_cnt_q     <= word_cnt_d;
        end
    end

    always_comb begin
        req_owner      = (owner_q == OWN_I) ? bus.REQ_VALID_I   : bus.REQ_VALID_D;
        ack_addr_owner = (owner_q == OWN_I) ? bus.ACK_ADDR_I    : bus.ACK_ADDR_D;
        ack_l1_owner   = (owner_q == OWN_I) ? bus.ACK_DATA_L1_I : bus.ACK_DATA_L1_D;
        addr_owner     = (owner_q == OWN_I) ? bus.ADDR_I        : bus.ADDR_D;
`ifdef L1D_PRIORITY_EN
        winner = bus.REQ_VALID_D ? OWN_D : OWN_I;
`else
        if (bus.REQ_VALID_D && bus.REQ_VALID_I) winner = (last_grant_q == OWN_I) ? OWN_D : OWN_I;
        else                                    winner = bus.REQ_VALID_D ? OWN_D : OWN_I;
`endif
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        mem_addr_d     = mem_addr_q;
        mem_ack_addr_d = 1'b0;
        // The forwarded ack only carries meaning while a fill is streaming.
        ack_l1_d       = (state_q == XFER) ? ack_l1_q : 4'hF;
        word_cnt_d     = word_cnt_q;
`ifndef L1D_PRIORITY_EN
        last_grant_d   = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.REQ_VALID_D || bus.REQ_VALID_I) begin
                    owner_d = winner;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!req_owner) begin
                    state_d = IDLE;
                end else if (bus.MEM_READY && ack_addr_owner) begin
                    mem_addr_d     = addr_owner;
                    mem_ack_addr_d = 1'b1;
                    word_cnt_d     = 4'd0;
                    state_d        = XFER;
                end
            end
            XFER: begin
                if (ack_l1_owner == word_cnt_q) begin
                    ack_l1_d = word_cnt_q;
                    // Hold the count on the last word so a 16-word line never wraps.
                    if (word_cnt_q == LAST_WORD) state_d    = DONE;
                    else                         word_cnt_d = word_cnt_q + 4'd1;
                end
            end
            DONE: begin
`ifndef L1D_PRIORITY_EN
                last_grant_d = owner_q;
`endif
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    logic granted, xfer;
    assign granted = (state_q == GRANT) || (state_q == XFER);
    assign xfer    = (state_q == XFER);

    assign bus.READY_D         = granted && (owner_q == OWN_D);
    assign bus.READY_I         = granted && (owner_q == OWN_I);
    assign bus.DATA_D          = (xfer && owner_q == OWN_D) ? bus.MEM_DATA : '0;
    assign bus.DATA_I          = (xfer && owner_q == OWN_I) ? bus.MEM_DATA : '0;
    assign bus.ACK_DATA_D      = (xfer && owner_q == OWN_D) ? bus.MEM_ACK_DATA : 4'hF;
    assign bus.ACK_DATA_I      = (xfer && owner_q == OWN_I) ? bus.MEM_ACK_DATA : 4'hF;
    assign bus.MEM_VALID       = ((state_q == GRANT) && req_owner) || xfer;
    assign bus.MEM_ADDR        = mem_addr_q;
    assign bus.MEM_ACK_ADDR    = mem_ack_addr_q;
    assign bus.MEM_ACK_DATA_L1 = ack_l1_q;
    assign bus.RESET_ACK       = (state_q == DONE);
endmodule

// File: tb/tb_l1_mem_arbiter.sv
// tb/tb_l1_mem_arbiter.sv - directed self-checking bench for l1_mem_arbiter
module tb_l1_mem_arbiter;
    logic CLK;
    logic RST_N;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   win2;

    l1_mem_arbiter_if #(.DATA_W(32)) bus ();

    l1_mem_arbiter #(.WORDS_PER_LINE(8), .DATA_W(32)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready_d"}, bus.READY_D, 0);
        chk({tag, "_ready_i"}, bus.READY_I, 0);
        chk({tag, "_data_d"}, bus.DATA_D, 0);
        chk({tag, "_data_i"}, bus.DATA_I, 0);
        chk({tag, "_ack_data_d"}, bus.ACK_DATA_D, 4'hF);
        chk({tag, "_ack_data_i"}, bus.ACK_DATA_I, 4'hF);
        chk({tag, "_mem_valid"}, bus.MEM_VALID, 0);
        chk({tag, "_mem_addr"}, bus.MEM_ADDR, 0);
        chk({tag, "_mem_ack_addr"}, bus.MEM_ACK_ADDR, 0);
        chk({tag, "_mem_ack_l1"}, bus.MEM_ACK_DATA_L1, 4'hF);
        chk({tag, "_reset_ack"}, bus.RESET_ACK, 0);
    endtask

    // Entered one step after the edge into GRANT; returns one step into the following IDLE.
    task automatic fill(input bit own_i, input logic [31:0] addr, input logic [31:0] base, input bit drop);
        bus.MEM_READY = 1'b1;
        if (own_i) bus.ACK_ADDR_I = 1'b1; else bus.ACK_ADDR_D = 1'b1;
        #1;
        chk("grant_ready_owner", own_i ? bus.READY_I : bus.READY_D, 1);
        chk("grant_ready_other", own_i ? bus.READY_D : bus.READY_I, 0);
        chk("grant_mem_valid", bus.MEM_VALID, 1);
        chk("grant_mem_ack_addr", bus.MEM_ACK_ADDR, 0);
        tick();
        bus.MEM_READY  = 1'b0;
        bus.ACK_ADDR_D = 1'b0;
        bus.ACK_ADDR_I = 1'b0;
        for (int w = 0; w < 8; w++) begin
            bus.MEM_DATA     = base + 32'(w);
            bus.MEM_ACK_DATA = 4'(w);
            if (own_i) bus.ACK_DATA_L1_I = 4'(w); else bus.ACK_DATA_L1_D = 4'(w);
            if (drop && w == 3) begin
                if (own_i) bus.REQ_VALID_I = 1'b0; else bus.REQ_VALID_D = 1'b0;
            end
            #1;
            chk("xfer_data_owner", own_i ? bus.DATA_I : bus.DATA_D, base + 32'(w));
            chk("xfer_ack_owner", own_i ? bus.ACK_DATA_I : bus.ACK_DATA_D, 32'(w));
            chk("xfer_data_other", own_i ? bus.DATA_D : bus.DATA_I, 0);
            chk("xfer_ack_other", own_i ? bus.ACK_DATA_D : bus.ACK_DATA_I, 4'hF);
            chk("xfer_ready_other", own_i ? bus.READY_D : bus.READY_I, 0);
            chk("xfer_ready_owner", own_i ? bus.READY_I : bus.READY_D, 1);
            chk("xfer_mem_valid", bus.MEM_VALID, 1);
            chk("xfer_reset_ack", bus.RESET_ACK, 0);
            if (w == 0) begin
                chk("xfer_mem_ack_addr_pulse", bus.MEM_ACK_ADDR, 1);
                chk("xfer_mem_addr", bus.MEM_ADDR, addr);
                chk("xfer_ack_l1_first", bus.MEM_ACK_DATA_L1, 4'hF);
            end else begin
                chk("xfer_mem_ack_addr_low", bus.MEM_ACK_ADDR, 0);
                chk("xfer_ack_l1", bus.MEM_ACK_DATA_L1, 32'(w - 1));
            end
            tick();
        end
        chk("done_reset_ack", bus.RESET_ACK, 1);
        chk("done_ready_d", bus.READY_D, 0);
        chk("done_ready_i", bus.READY_I, 0);
        chk("done_mem_valid", bus.MEM_VALID, 0);
        chk("done_ack_l1", bus.MEM_ACK_DATA_L1, 7);
        tick();
        bus.ACK_DATA_L1_D = 4'hF;
        bus.ACK_DATA_L1_I = 4'hF;
        bus.MEM_DATA      = '0;
        bus.MEM_ACK_DATA  = 4'h0;
        #1;
        chk("idle_reset_ack", bus.RESET_ACK, 0);
        chk("idle_ack_l1", bus.MEM_ACK_DATA_L1, 4'hF);
    endtask

    initial begin
        RST_N             = 1'b0;
        bus.REQ_VALID_D   = 1'b0;
        bus.REQ_VALID_I   = 1'b0;
        bus.ADDR_D        = '0;
        bus.ADDR_I        = '0;
        bus.ACK_ADDR_D    = 1'b0;
        bus.ACK_ADDR_I    = 1'b0;
        bus.ACK_DATA_L1_D = 4'hF;
        bus.ACK_DATA_L1_I = 4'hF;
        bus.MEM_READY     = 1'b0;
        bus.MEM_DATA      = '0;
        bus.MEM_ACK_DATA  = 4'h0;
        tick();
        chk_reset_outputs("reset");
        RST_N = 1'b1;

        // Simultaneous requests: D wins the first contest after reset; D keeps requesting.
        bus.REQ_VALID_D = 1'b1;
        bus.REQ_VALID_I = 1'b1;
        bus.ADDR_D      = 32'h0000_0100;
        bus.ADDR_I      = 32'h0000_0200;
        #1;
        chk("idle_no_ready_d", bus.READY_D, 0);
        chk("idle_no_mem_valid", bus.MEM_VALID, 0);
        tick();
        fill(1'b0, 32'h0000_0100, 32'h10, 1'b0);
`ifdef L1D_PRIORITY_EN
        win2 = 1'b0;
`else
        win2 = 1'b1;
`endif
        tick();
        fill(win2, win2 ? 32'h0000_0200 : 32'h0000_0100, 32'h20, 1'b1);
        bus.REQ_VALID_D = 1'b0;
        bus.REQ_VALID_I = 1'b0;
        tick();
        chk("quiet_ready_d", bus.READY_D, 0);
        chk("quiet_ready_i", bus.READY_I, 0);
        chk("quiet_mem_valid", bus.MEM_VALID, 0);

        // Single D miss at 0x40, words 0xA0..0xA7.
        bus.REQ_VALID_D = 1'b1;
        bus.ADDR_D      = 32'h0000_0040;
        tick();
        fill(1'b0, 32'h0000_0040, 32'hA0, 1'b1);

        // D withdraws in GRANT before MEM_READY; pending I is then served.
        bus.REQ_VALID_D = 1'b1;
        bus.ADDR_D      = 32'h0000_0080;
        tick();
        bus.REQ_VALID_D = 1'b0;
        bus.REQ_VALID_I = 1'b1;
        bus.ADDR_I      = 32'h0000_0300;
        #1;
        chk("abort_mem_valid", bus.MEM_VALID, 0);
        chk("abort_ready_i", bus.READY_I, 0);
        tick();
        chk("abort_idle_ready_d", bus.READY_D, 0);
        chk("abort_no_ack_addr", bus.MEM_ACK_ADDR, 0);
        chk("abort_mem_addr_kept", bus.MEM_ADDR, 32'h0000_0040);
        tick();
        fill(1'b1, 32'h0000_0300, 32'h30, 1'b1);

        // I fill with an out-of-order ack, then reset at word 4.
        bus.REQ_VALID_I = 1'b1;
        bus.ADDR_I      = 32'h0000_0500;
        tick();
        bus.MEM_READY  = 1'b1;
        bus.ACK_ADDR_I = 1'b1;
        tick();
        bus.MEM_READY  = 1'b0;
        bus.ACK_ADDR_I = 1'b0;
        for (int w = 0; w < 2; w++) begin
            bus.MEM_DATA      = 32'h50 + 32'(w);
            bus.MEM_ACK_DATA  = 4'(w);
            bus.ACK_DATA_L1_I = 4'(w);
            tick();
        end
        bus.MEM_DATA      = 32'h52;
        bus.MEM_ACK_DATA  = 4'd2;
        bus.ACK_DATA_L1_I = 4'd3;
        #1;
        chk("skip_ack_l1_before", bus.MEM_ACK_DATA_L1, 1);
        tick();
        chk("skip_ack_l1_held", bus.MEM_ACK_DATA_L1, 1);
        chk("skip_ack_data_i", bus.ACK_DATA_I, 2);
        bus.ACK_DATA_L1_I = 4'd2;
        tick();
        chk("skip_ack_l1_advanced", bus.MEM_ACK_DATA_L1, 2);
        bus.MEM_DATA      = 32'h53;
        bus.MEM_ACK_DATA  = 4'd3;
        bus.ACK_DATA_L1_I = 4'd3;
        tick();
        bus.MEM_DATA     = 32'h54;
        bus.MEM_ACK_DATA = 4'd4;
        #1;
        chk("word4_data_i", bus.DATA_I, 32'h54);
        RST_N = 1'b0;
        #1;
        chk_reset_outputs("midfill_reset");
        tick();
        chk("midfill_reset_edge_reset_ack", bus.RESET_ACK, 0);
        chk("midfill_reset_edge_ready_i", bus.READY_I, 0);
        bus.REQ_VALID_I   = 1'b0;
        bus.ACK_DATA_L1_I = 4'hF;
        bus.MEM_DATA      = '0;
        bus.MEM_ACK_DATA  = 4'h0;
        RST_N             = 1'b1;

        bus.REQ_VALID_D = 1'b1;
        bus.ADDR_D      = 32'h0000_0600;
        tick();
        fill(1'b0, 32'h0000_0600, 32'h60, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
